// File: rtl/folded_accumulator.sv
// folded_accumulator
// Reduces TAPS signed products, delivered LANES at a time over
// BEATS = ceil(TAPS/LANES) input beats. The data path is:
//   - lane masking
//   - a fully registered binary adder tree
//   - a running accumulator
//   - round / saturate to OUTBITS
//
// Ports:
//   clk            rising-edge clock for all logic
//   rst            synchronous, active-high reset
//   in_valid       multiplier_out holds a valid beat this cycle
//   multiplier_out LANES signed products of MULTBITS each
//   out            signed, rounded, saturated result (holds until next result)
//   out_valid      one-cycle pulse when out is updated
//   out_sat        out was clamped; qualified by out_valid
module folded_accumulator #(
  parameter int TAPS     = 401,
  parameter int MULTBITS = 32,
  parameter int LANES    = 64,
  parameter int OUTBITS  = 32,
  parameter int SHIFT    = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic signed [MULTBITS-1:0] multiplier_out [0:LANES-1],
  output logic signed [OUTBITS-1:0]  out,
  output logic                       out_valid,
  output logic                       out_sat
);

  localparam int LOGP     = $clog2(LANES);
  localparam int P        = 1 << LOGP;
  localparam int BEATS    = (TAPS + LANES - 1) / LANES;
  localparam int CNTW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int TREEBITS = MULTBITS + LOGP;
  localparam int ACCUBITS = MULTBITS + $clog2(TAPS);
  // One extra bit so adding the rounding constant can never overflow.
  localparam int RNDBITS  = ACCUBITS + 1;
  // Comparison width must also be able to represent the output limits.
  localparam int CMPBITS  = (RNDBITS > OUTBITS) ? RNDBITS : OUTBITS + 1;

  localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(BEATS - 1);
  // Half an LSB of the shifted result. This is 0 when SHIFT is 0, so the
  // same expression then passes acc through unchanged.
  localparam logic signed [RNDBITS-1:0] HALF =
    RNDBITS'((64'(1) << SHIFT) >> 1);
  localparam logic signed [CMPBITS-1:0] OUT_MAX =
    CMPBITS'((64'(1) << (OUTBITS - 1)) - 64'(1));
  localparam logic signed [CMPBITS-1:0] OUT_MIN = -OUT_MAX - CMPBITS'(1);

  logic [CNTW-1:0]             in_cnt;
  logic                        in_first;
  logic                        in_last;

  // Tree stored heap-style: node k has children 2k+1 and 2k+2.
  //   - Indices 0..P-2 are registered internal nodes.
  //   - Indices P-1..2P-2 are the combinational (masked) input lanes.
  // Every internal node is a register, so each leaf reaches the root after
  // exactly LOGP edges.
  logic signed [TREEBITS-1:0]  node_q [0:P-2];
  logic signed [TREEBITS-1:0]  child  [1:2*P-2];

  logic [LOGP-1:0]             vld_pipe;
  logic [LOGP-1:0]             first_pipe;
  logic [LOGP-1:0]             last_pipe;

  logic signed [ACCUBITS-1:0]  acc;
  logic                        acc_done;
  logic signed [RNDBITS-1:0]   rounded;
  logic signed [CMPBITS-1:0]   r_ext;

  assign in_first = (in_cnt == '0);
  assign in_last  = (in_cnt == LAST_BEAT);

  // Beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_cnt <= '0;
    end else if (in_valid) begin
      in_cnt <= in_last ? '0 : in_cnt + 1'b1;
    end
  end

  // Gather the tree operands.
  // Lanes past TAPS in the final beat, and the pad lanes LANES..P-1,
  // contribute zero.
  always_comb begin
    for (int i = 1; i <= 2*P-2; i++) begin
      child[i] = '0;
    end
    for (int i = 1; i < P-1; i++) begin
      child[i] = node_q[i];
    end
    for (int j = 0; j < LANES; j++) begin
      if (int'(in_cnt) * LANES + j < TAPS) begin
        child[P-1+j] = TREEBITS'(multiplier_out[j]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < P-1; k++) begin
        node_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < P-1; k++) begin
        node_q[k] <= child[2*k+1] + child[2*k+2];
      end
    end
  end

  // valid/first/last tags, aligned with the tree root.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe   <= '0;
      first_pipe <= '0;
      last_pipe  <= '0;
    end else begin
      vld_pipe[0]   <= in_valid;
      first_pipe[0] <= in_first;
      last_pipe[0]  <= in_last;
      for (int i = 1; i < LOGP; i++) begin
        vld_pipe[i]   <= vld_pipe[i-1];
        first_pipe[i] <= first_pipe[i-1];
        last_pipe[i]  <= last_pipe[i-1];
      end
    end
  end

  // A first-tagged partial restarts the sum. This also covers the
  // single-beat case, where first and last are both set.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      acc_done <= 1'b0;
    end else begin
      acc_done <= vld_pipe[LOGP-1] & last_pipe[LOGP-1];
      if (vld_pipe[LOGP-1]) begin
        acc <= first_pipe[LOGP-1] ? ACCUBITS'(node_q[0])
                                  : acc + ACCUBITS'(node_q[0]);
      end
    end
  end

  always_comb begin
    rounded = (RNDBITS'(acc) + HALF) >>> SHIFT;
    r_ext   = CMPBITS'(rounded);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
      out_sat   <= 1'b0;
    end else begin
      out_valid <= acc_done;
      if (acc_done) begin
        if (r_ext > OUT_MAX) begin
          out     <= OUT_MAX[OUTBITS-1:0];
          out_sat <= 1'b1;
        end else if (r_ext < OUT_MIN) begin
          out     <= OUT_MIN[OUTBITS-1:0];
          out_sat <= 1'b1;
        end else begin
          out     <= r_ext[OUTBITS-1:0];
          out_sat <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_folded_accumulator.sv
// tb_folded_accumulator
// Directed bench for folded_accumulator using two instances:
//   dut_a: TAPS=10, LANES=4, MULTBITS=16, OUTBITS=16, SHIFT=2 (three beats)
//   dut_b: TAPS=4,  LANES=4, MULTBITS=16, OUTBITS=16, SHIFT=0 (single beat)
module tb_folded_accumulator;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid_a;
  logic               in_valid_b;
  logic signed [15:0] lanes_a [0:3];
  logic signed [15:0] lanes_b [0:3];
  logic signed [15:0] out_a;
  logic signed [15:0] out_b;
  logic               out_valid_a;
  logic               out_valid_b;
  logic               out_sat_a;
  logic               out_sat_b;

  int tests_run    = 0;
  int tests_failed = 0;

  logic signed [15:0] outs_a [$];

  folded_accumulator #(
    .TAPS(10), .MULTBITS(16), .LANES(4), .OUTBITS(16), .SHIFT(2)
  ) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .multiplier_out(lanes_a),
    .out(out_a), .out_valid(out_valid_a), .out_sat(out_sat_a)
  );

  folded_accumulator #(
    .TAPS(4), .MULTBITS(16), .LANES(4), .OUTBITS(16), .SHIFT(0)
  ) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .multiplier_out(lanes_b),
    .out(out_b), .out_valid(out_valid_b), .out_sat(out_sat_b)
  );

  always #5 clk = ~clk;

  // Record every result pulse of dut_a.
  always @(negedge clk) begin
    if (out_valid_a === 1'b1) outs_a.push_back(out_a);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes_a(input logic signed [15:0] v);
    for (int j = 0; j < 4; j++) lanes_a[j] = v;
  endtask

  task automatic send_sample_a(input logic signed [15:0] v);
    in_valid_a = 1'b1;
    set_lanes_a(v);
    repeat (3) tick();
    in_valid_a = 1'b0;
    set_lanes_a(16'sd0);
  endtask

  // Returns the edge count (the final-beat edge is 1) at which out_valid
  // was seen. Bounded at 20.
  task automatic wait_out_a(output int lat);
    lat = 1;
    while (out_valid_a !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid_a = 1'b1;
    set_lanes_a(16'sd7);
    in_valid_b = 1'b0;
    for (int j = 0; j < 4; j++) lanes_b[j] = 16'sd0;
    repeat (2) tick();
    tests_run++;
    if (out_a !== 16'sd0) begin tests_failed++; $display("[TB] FAIL reset_out_a: got %0d, expected 0", out_a); end
    tests_run++;
    if (out_valid_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid_a: got %b, expected 0", out_valid_a); end
    tests_run++;
    if (out_sat_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_sat_a: got %b, expected 0", out_sat_a); end
    tests_run++;
    if (out_b !== 16'sd0 || out_valid_b !== 1'b0 || out_sat_b !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_b: got out=%0d valid=%b sat=%b, expected all 0", out_b, out_valid_b, out_sat_b);
    end
    rst = 1'b0;
    in_valid_a = 1'b0;
    set_lanes_a(16'sd0);
  endtask

  task automatic test_ones();
    send_sample_a(16'sd1);
    tick();
    tests_run++;
    if (out_valid_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL ones_early2: got valid %b, expected 0", out_valid_a); end
    tick();
    tests_run++;
    if (out_valid_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL ones_early3: got valid %b, expected 0", out_valid_a); end
    tick();
    tests_run++;
    if (out_valid_a !== 1'b1) begin tests_failed++; $display("[TB] FAIL ones_valid: got valid %b, expected 1", out_valid_a); end
    tests_run++;
    if (out_a !== 16'sd3) begin tests_failed++; $display("[TB] FAIL ones_out: got %0d, expected 3", out_a); end
    tests_run++;
    if (out_sat_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL ones_sat: got %b, expected 0", out_sat_a); end
    tick();
    tests_run++;
    if (out_valid_a !== 1'b0 || out_a !== 16'sd3) begin
      tests_failed++;
      $display("[TB] FAIL ones_hold: got valid=%b out=%0d, expected valid=0 out=3", out_valid_a, out_a);
    end
  endtask

  task automatic test_negative();
    int lat;
    send_sample_a(-16'sd1);
    wait_out_a(lat);
    tests_run++;
    if (lat != 4) begin tests_failed++; $display("[TB] FAIL neg_latency: got %0d edges, expected 4", lat); end
    tests_run++;
    if (out_a !== 16'shFFFE || out_sat_a !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL neg_out: got out=%0d sat=%b, expected out=-2 sat=0", out_a, out_sat_a);
    end
    tick();
  endtask

  task automatic test_sat_max();
    int lat;
    send_sample_a(16'sh7FFF);
    wait_out_a(lat);
    tests_run++;
    if (lat != 4) begin tests_failed++; $display("[TB] FAIL satmax_latency: got %0d edges, expected 4", lat); end
    tests_run++;
    if (out_a !== 16'sh7FFF || out_sat_a !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL satmax_out: got out=%0d sat=%b, expected out=32767 sat=1", out_a, out_sat_a);
    end
    tick();
  endtask

  task automatic test_sat_min();
    int lat;
    send_sample_a(16'sh8000);
    wait_out_a(lat);
    tests_run++;
    if (lat != 4) begin tests_failed++; $display("[TB] FAIL satmin_latency: got %0d edges, expected 4", lat); end
    tests_run++;
    if (out_a !== 16'sh8000 || out_sat_a !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL satmin_out: got out=%0d sat=%b, expected out=-32768 sat=1", out_a, out_sat_a);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    outs_a.delete();
    in_valid_a = 1'b1;
    set_lanes_a(16'sd1);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    tests_run++;
    if (out_a !== 16'sd0 || out_sat_a !== 1'b0 || out_valid_a !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_clear: got out=%0d sat=%b valid=%b, expected all 0", out_a, out_sat_a, out_valid_a);
    end
    rst = 1'b0;
    repeat (3) tick();
    in_valid_a = 1'b0;
    set_lanes_a(16'sd0);
    repeat (8) tick();
    tests_run++;
    if (outs_a.size() != 1) begin
      tests_failed++;
      $display("[TB] FAIL midreset_pulses: got %0d pulses, expected 1", outs_a.size());
    end else begin
      tests_run++;
      if (outs_a[0] !== 16'sd3) begin tests_failed++; $display("[TB] FAIL midreset_out: got %0d, expected 3", outs_a[0]); end
    end
  endtask

  task automatic test_back_to_back();
    outs_a.delete();
    in_valid_a = 1'b1; set_lanes_a(16'sd1); tick();
    in_valid_a = 1'b0; repeat (2) tick();
    in_valid_a = 1'b1; set_lanes_a(16'sd2); tick();
    in_valid_a = 1'b0; repeat (2) tick();
    in_valid_a = 1'b1; set_lanes_a(16'sd3); tick();
    set_lanes_a(16'sd4);
    repeat (3) tick();
    in_valid_a = 1'b0;
    set_lanes_a(16'sd0);
    tests_run++;
    if (out_valid_a !== 1'b1 || out_a !== 16'sd5) begin
      tests_failed++;
      $display("[TB] FAIL b2b_first: got valid=%b out=%0d, expected valid=1 out=5", out_valid_a, out_a);
    end
    tick();
    tests_run++;
    if (out_valid_a !== 1'b0 || out_a !== 16'sd5) begin
      tests_failed++;
      $display("[TB] FAIL b2b_hold: got valid=%b out=%0d, expected valid=0 out=5", out_valid_a, out_a);
    end
    repeat (2) tick();
    tests_run++;
    if (out_valid_a !== 1'b1 || out_a !== 16'sd10) begin
      tests_failed++;
      $display("[TB] FAIL b2b_second: got valid=%b out=%0d, expected valid=1 out=10", out_valid_a, out_a);
    end
    repeat (4) tick();
    tests_run++;
    if (outs_a.size() != 2) begin
      tests_failed++;
      $display("[TB] FAIL b2b_pulses: got %0d pulses, expected 2", outs_a.size());
    end
  endtask

  task automatic test_single_beat();
    logic exp_v;
    for (int j = 0; j < 4; j++) lanes_b[j] = 16'(j + 1);
    for (int k = 1; k <= 10; k++) begin
      in_valid_b = (k <= 5);
      tick();
      exp_v = (k >= 4 && k <= 8);
      tests_run++;
      if (out_valid_b !== exp_v) begin
        tests_failed++;
        $display("[TB] FAIL single_valid_%0d: got %b, expected %b", k, out_valid_b, exp_v);
      end
      if (exp_v) begin
        tests_run++;
        if (out_b !== 16'sd10 || out_sat_b !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL single_out_%0d: got out=%0d sat=%b, expected out=10 sat=0", k, out_b, out_sat_b);
        end
      end
    end
    in_valid_b = 1'b0;
  endtask

  initial begin
    $display("[TB] folded_accumulator bench start");
    test_reset();
    test_ones();
    test_negative();
    test_sat_max();
    test_sat_min();
    test_reset_mid();
    test_back_to_back();
    test_single_beat();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
